display_scan_ctrl: RTL

- Time-multiplexes NUM_DIG hex digits onto one shared active-low 7-segment bus and anode set; the segment bus is the resource being shared.
- An internal programmable ratio counter paces the scan. Its divide ratio is the same kind of quantity used by the team's frequency divider.
- Each digit slot is a requester with its own enable.
- Sits between the adder result registers and the board display pins.

---
 rtl/display_scan_ctrl_if.sv | 34 +++
 rtl/display_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: bus between the adder result registers and the display scanner.
//   ratio      requested clocks per digit slot
//   ratio_load 1-cycle pulse; captures ratio into the pending register
//   digitos    hex value per digit, digit k = digitos[4k+3:4k]
//   habilita   per-digit enable
//   anodos     active-low digit select, at most one bit low
//   segmentos  active-low segments {g,f,e,d,c,b,a}
//   tick       1-cycle pulse on the last clock of each digit slot
//   sel        index of the digit currently owning the segment bus
// master = producer of digit data (and consumer of display pins); slave = scanner.
interface display_scan_ctrl_if #(
   parameter int unsigned NUM_DIG = 4
);
   localparam int unsigned SEL_W = $clog2(NUM_DIG);

   logic [31:0]          ratio;
   logic                 ratio_load;
   logic [4*NUM_DIG-1:0] digitos;
   logic [NUM_DIG-1:0]   habilita;
   logic [NUM_DIG-1:0]   anodos;
   logic [6:0]           segmentos;
   logic                 tick;
   logic [SEL_W-1:0]     sel;

   modport master (
      output ratio, ratio_load, digitos, habilita,
      input  anodos, segmentos, tick, sel
   );

   modport slave (
      input  ratio, ratio_load, digitos, habilita,
      output anodos, segmentos, tick, sel
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes NUM_DIG hex digits onto one active-low 7-segment bus.
// Each slot is ratio_act clocks: BLANK_CYC clocks with all anodes off, then the digit shown.
// Enabled digits are served round-robin; a new ratio is applied only at a slot boundary.
// Ports:
//   entrada     system clock (posedge)
//   reinicio_n  synchronous active-low reset
//   bus         display_scan_ctrl_if.slave (ratio/ratio_load/digitos/habilita in,
//               anodos/segmentos/tick/sel out)
// Optional build macro: DISPLAY_LZ_BLANK_EN - blank leading zero digits (digit 0 always shown).
module display_scan_ctrl #(
   parameter int unsigned NUM_DIG       = 4,
   parameter int unsigned DEFAULT_RATIO = 50000,
   parameter int unsigned BLANK_CYC     = 4
) (
   input logic                entrada,
   input logic                reinicio_n,
   display_scan_ctrl_if.slave bus
);
   localparam int unsigned SEL_W     = $clog2(NUM_DIG);
   localparam logic [31:0] MIN_RATIO = 32'(BLANK_CYC + 1);
   localparam logic [31:0] BLANK_END = 32'(BLANK_CYC - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   logic [1:0]         r_state;
   logic [31:0]        r_cuenta;
   logic [31:0]        r_ratio_act;
   logic [31:0]        r_ratio_pend;
   logic               r_pend_valid;
   logic [SEL_W-1:0]   r_sel;
   logic [NUM_DIG-1:0] r_anodos;
   logic [6:0]         r_segmentos;

   logic [31:0]        w_load_val;
   logic               w_tick;
   logic               w_apply;
   logic               w_any;
   logic [SEL_W-1:0]   w_first;
   logic [SEL_W-1:0]   w_next;
   logic [3:0]         w_dig;
   logic               w_blank;

   function automatic logic [6:0] f_hex7(input logic [3:0] v);
      case (v)
         4'h0: f_hex7 = 7'h40;
         4'h1: f_hex7 = 7'h79;
         4'h2: f_hex7 = 7'h24;
         4'h3: f_hex7 = 7'h30;
         4'h4: f_hex7 = 7'h19;
         4'h5: f_hex7 = 7'h12;
         4'h6: f_hex7 = 7'h02;
         4'h7: f_hex7 = 7'h78;
         4'h8: f_hex7 = 7'h00;
         4'h9: f_hex7 = 7'h10;
         4'hA: f_hex7 = 7'h08;
         4'hB: f_hex7 = 7'h03;
         4'hC: f_hex7 = 7'h46;
         4'hD: f_hex7 = 7'h21;
         4'hE: f_hex7 = 7'h06;
         default: f_hex7 = 7'h0E;
      endcase
   endfunction

   // Ratios at or below the blank window would leave no show time (this also covers 0 and 1).
   assign w_load_val = (bus.ratio <= 32'(BLANK_CYC)) ? MIN_RATIO : bus.ratio;

   // The last slot clock always falls in S_SHOW since ratio_act > BLANK_CYC.
   assign w_tick  = (r_state == S_SHOW) && (r_cuenta == r_ratio_act - 32'd1);
   assign w_apply = r_pend_valid && (w_tick || (r_state == S_IDLE));
   assign w_any   = |bus.habilita;
   assign w_dig   = bus.digitos[4*r_sel +: 4];

   // w_first: lowest enabled index. w_next: first enabled index after r_sel, wrapping;
   // falls back to r_sel when it is the only enabled digit.
   always_comb begin
      int unsigned v_idx;
      w_first = '0;
      w_next  = r_sel;
      v_idx   = 0;
      for (int i = NUM_DIG - 1; i >= 0; i--) begin
         if (bus.habilita[i]) w_first = SEL_W'(i);
      end
      for (int k = NUM_DIG - 1; k >= 1; k--) begin
         v_idx = (int'(r_sel) + k) % NUM_DIG;
         if (bus.habilita[v_idx]) w_next = SEL_W'(v_idx);
      end
   end

`ifdef DISPLAY_LZ_BLANK_EN
   // Blank digit sel>0 when it and every higher enabled digit are zero.
   always_comb begin
      logic v_lead;
      v_lead = 1'b1;
      for (int j = NUM_DIG - 1; j > 0; j--) begin
         if ((j > int'(r_sel)) && bus.habilita[j] && (bus.digitos[4*j +: 4] != 4'h0)) begin
            v_lead = 1'b0;
         end
      end
      w_blank = (r_sel != '0) && (w_dig == 4'h0) && v_lead;
   end
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge entrada) begin
      if (!reinicio_n) begin
         r_state      <= S_IDLE;
         r_cuenta     <= '0;
         r_ratio_act  <= 32'(DEFAULT_RATIO);
         r_ratio_pend <= 32'(DEFAULT_RATIO);
         r_pend_valid <= 1'b0;
         r_sel        <= '0;
         r_anodos     <= '1;
         r_segmentos  <= 7'h7F;
      end else begin
         // A load coinciding with the apply point stays pending for the next boundary.
         if (bus.ratio_load) begin
            r_ratio_pend <= w_load_val;
            r_pend_valid <= 1'b1;
         end else if (w_apply) begin
            r_pend_valid <= 1'b0;
         end
         if (w_apply) r_ratio_act <= r_ratio_pend;

         case (r_state)
            S_IDLE: begin
               r_cuenta <= '0;
               if (w_any) begin
                  r_state <= S_BLANK;
                  r_sel   <= w_first;
               end
            end
            S_BLANK: begin
               r_cuenta <= r_cuenta + 32'd1;
               if (r_cuenta == BLANK_END) begin
                  r_state <= S_SHOW;
                  if (w_blank) begin
                     r_segmentos <= 7'h7F;
                  end else begin
                     r_segmentos <= f_hex7(w_dig);
                     r_anodos    <= ~(NUM_DIG'(1) << r_sel);
                  end
               end
            end
            S_SHOW: begin
               if (w_tick) begin
                  r_cuenta <= '0;
                  // Segments are left as-is so they never move together with the anodes here.
                  r_anodos <= '1;
                  if (w_any) begin
                     r_state <= S_BLANK;
                     r_sel   <= w_next;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cuenta <= r_cuenta + 32'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.anodos    = r_anodos;
   assign bus.segmentos = r_segmentos;
   assign bus.tick      = w_tick;
   assign bus.sel       = r_sel;
endmodule
